// File: rtl/keypress_sequencer_pkg.sv
// Shared definitions for the keypress sequencer and its consumers.
// Holds state encodings, the default debounce length and the key encoder.
package keypress_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_t;

    localparam int DEBOUNCE_DEFAULT = 50000;

    // Zero input maps to index 0; callers only pass one-hot values.
    function automatic logic [1:0] encode_key(input logic [3:0] k);
        logic [1:0] idx;
        idx = 2'd0;
        unique case (1'b1)
            k[0]:    idx = 2'd0;
            k[1]:    idx = 2'd1;
            k[2]:    idx = 2'd2;
            k[3]:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypress_sequencer_stability_counter.sv
// Stability counter shared by the press and release debounce phases.
// Terminal flags when the pattern has been stable for DEBOUNCE_CYCLES edges.
module stability_counter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic terminal
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CNT_WIDTH'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/keypress_sequencer.sv
// Debounces the filtered key vector into one event per press/release cycle.
// Events are held in a single valid/ready slot; drops set a sticky flag.
module keypress_sequencer
    import keypress_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_WIDTH       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] filteredkey,
    input  logic       press_ready,
    input  logic       overflow_clear,
    output logic       press_valid,
    output logic [1:0] press_index,
    output logic       key_held,
    output logic       overflow
);

    kp_state_t  state, state_nxt;
    logic [3:0] candidate, cand_nxt;
    logic       cnt_clr, cnt_inc, cnt_done;
    logic       fire, accept, drop;

    stability_counter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clr),
        .incr    (cnt_inc),
        .terminal(cnt_done)
    );

    always_comb begin
        state_nxt = state;
        cand_nxt  = candidate;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        fire      = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (enable && filteredkey != 4'd0) begin
                    cand_nxt  = filteredkey;
                    state_nxt = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!enable || filteredkey != candidate) begin
                    state_nxt = IDLE;
                    cnt_clr   = 1'b1;
                end else if (cnt_done) begin
                    state_nxt = HELD;
                    fire      = 1'b1;
                    cnt_clr   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HELD: begin
                cnt_clr = 1'b1;
                if (filteredkey != candidate) begin
                    state_nxt = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                // Any other key restarts the zero period without leaving release.
                if (filteredkey == 4'd0) begin
                    if (cnt_done) begin
                        state_nxt = IDLE;
                        cnt_clr   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (filteredkey == candidate) begin
                    state_nxt = HELD;
                    cnt_clr   = 1'b1;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    assign accept = fire && (!press_valid || press_ready);
    assign drop   = fire && press_valid && !press_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            candidate   <= 4'd0;
            press_valid <= 1'b0;
            press_index <= 2'd0;
            key_held    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state     <= state_nxt;
            candidate <= cand_nxt;
            key_held  <= (state_nxt == HELD) || (state_nxt == RELEASE_DB);
            if (accept) begin
                press_valid <= 1'b1;
                press_index <= encode_key(candidate);
            end else if (press_valid && press_ready) begin
                press_valid <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
